// File: rtl/id_decode_stage.sv
// id_decode_stage: RV32I instruction decode with a one-entry output register.
// Decodes opcode/funct3/funct7 into the 5-bit ALU control code
// {branch, sub/arith, funct3}, the sign-extended immediate, the register
// indices and the control enables. The decoded entry is handed to the
// execute stage over a valid/ready handshake.
// Illegal encodings still flow downstream (illegal=1, enables cleared) so the
// core can trap. Immediate and register-index fields of an illegal entry
// carry whatever the opcode's format yields (zero immediate for unknown
// opcodes).
module id_decode_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] pc_in,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            alu_control,
  output logic                  alu_src_imm,
  output logic [DATA_WIDTH-1:0] imm,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic                  reg_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  is_jump,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic                  illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  // Immediate extraction helpers, one per RV32I format.
  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  logic [6:0]            opcode_s;
  logic [2:0]            funct3_s;
  logic [6:0]            funct7_s;
  logic                  xfer_in_s;
  logic                  xfer_out_s;

  logic [4:0]            alu_control_d;
  logic                  alu_src_imm_d;
  logic [31:0]           imm32_s;
  logic [DATA_WIDTH-1:0] imm_d;
  logic [4:0]            rs1_d;
  logic [4:0]            rs2_d;
  logic [4:0]            rd_d;
  logic                  reg_write_d;
  logic                  mem_read_d;
  logic                  mem_write_d;
  logic                  is_jump_d;
  logic                  illegal_d;
  logic                  out_valid_d;

  logic [4:0]            alu_control_q;
  logic                  alu_src_imm_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic [4:0]            rs1_q;
  logic [4:0]            rs2_q;
  logic [4:0]            rd_q;
  logic                  reg_write_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic                  is_jump_q;
  logic                  illegal_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic                  out_valid_q;

  assign opcode_s   = instr[6:0];
  assign funct3_s   = instr[14:12];
  assign funct7_s   = instr[31:25];

  // A flush blocks acceptance so fetch holds its instruction through it.
  assign in_ready   = (!out_valid_q || out_ready) && !flush;
  assign xfer_in_s  = in_valid && in_ready;
  assign xfer_out_s = out_valid_q && out_ready;

  // Decode the presented instruction into the next entry's fields.
  always_comb begin
    alu_control_d = 5'b00000;
    alu_src_imm_d = 1'b0;
    imm32_s       = 32'h0000_0000;
    rs1_d         = instr[19:15];
    rs2_d         = instr[24:20];
    rd_d          = instr[11:7];
    reg_write_d   = 1'b0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    is_jump_d     = 1'b0;
    illegal_d     = 1'b0;

    case (opcode_s)
      OP_R: begin
        reg_write_d = 1'b1;
        // Only add/sub and srl/sra have an alternate funct7 encoding.
        if ((funct7_s == F7_ZERO) ||
            ((funct7_s == F7_ALT) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)))) begin
          alu_control_d = {1'b0, funct7_s[5], funct3_s};
        end else begin
          illegal_d = 1'b1;
        end
      end
      OP_IMM: begin
        reg_write_d   = 1'b1;
        alu_src_imm_d = 1'b1;
        alu_control_d = {1'b0, (funct3_s == 3'b101) ? funct7_s[5] : 1'b0, funct3_s};
        // Shifts carry a zero-extended shamt rather than a signed immediate.
        if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
          imm32_s = {27'b0, instr[24:20]};
        end else begin
          imm32_s = imm_i(instr);
        end
        case (funct3_s)
          3'b001:  illegal_d = (funct7_s != F7_ZERO);
          3'b101:  illegal_d = !((funct7_s == F7_ZERO) || (funct7_s == F7_ALT));
          default: illegal_d = 1'b0;
        endcase
      end
      OP_BRANCH: begin
        alu_control_d = {2'b10, funct3_s};
        imm32_s       = imm_b(instr);
        illegal_d     = (funct3_s == 3'b010) || (funct3_s == 3'b011);
      end
      OP_LOAD: begin
        alu_src_imm_d = 1'b1;
        imm32_s       = imm_i(instr);
        mem_read_d    = 1'b1;
        reg_write_d   = 1'b1;
      end
      OP_STORE: begin
        alu_src_imm_d = 1'b1;
        imm32_s       = imm_s(instr);
        mem_write_d   = 1'b1;
      end
      OP_LUI: begin
        // rs1 forced to x0 so execute computes 0 + imm.
        alu_src_imm_d = 1'b1;
        imm32_s       = imm_u(instr);
        rs1_d         = 5'd0;
        reg_write_d   = 1'b1;
      end
      OP_AUIPC: begin
        alu_src_imm_d = 1'b1;
        imm32_s       = imm_u(instr);
        reg_write_d   = 1'b1;
      end
      OP_JAL: begin
        alu_src_imm_d = 1'b1;
        imm32_s       = imm_j(instr);
        reg_write_d   = 1'b1;
        is_jump_d     = 1'b1;
      end
      OP_JALR: begin
        alu_src_imm_d = 1'b1;
        imm32_s       = imm_i(instr);
        reg_write_d   = 1'b1;
        is_jump_d     = 1'b1;
      end
      default: begin
        illegal_d = 1'b1;
      end
    endcase

    // Illegal entries must not perform any side effect downstream.
    if (illegal_d) begin
      alu_control_d = 5'b00000;
      alu_src_imm_d = 1'b0;
      reg_write_d   = 1'b0;
      mem_read_d    = 1'b0;
      mem_write_d   = 1'b0;
      is_jump_d     = 1'b0;
    end else begin
      illegal_d     = 1'b0;
    end

    imm_d = DATA_WIDTH'($signed(imm32_s));
  end

  // Next occupancy of the output register: flush wins, then load, then drain.
  always_comb begin
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (xfer_in_s) begin
      out_valid_d = 1'b1;
    end else if (xfer_out_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Occupancy flag of the pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
    end
  end

  // Payload of the pipeline register; loaded only on an accepted instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_control_q <= 5'b00000;
      alu_src_imm_q <= 1'b0;
      imm_q         <= '0;
      rs1_q         <= 5'd0;
      rs2_q         <= 5'd0;
      rd_q          <= 5'd0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      is_jump_q     <= 1'b0;
      illegal_q     <= 1'b0;
      pc_q          <= '0;
    end else if (xfer_in_s) begin
      alu_control_q <= alu_control_d;
      alu_src_imm_q <= alu_src_imm_d;
      imm_q         <= imm_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      is_jump_q     <= is_jump_d;
      illegal_q     <= illegal_d;
      pc_q          <= pc_in;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_control = alu_control_q;
  assign alu_src_imm = alu_src_imm_q;
  assign imm         = imm_q;
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign rd          = rd_q;
  assign reg_write   = reg_write_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign is_jump     = is_jump_q;
  assign illegal     = illegal_q;
  assign pc_out      = pc_q;

endmodule
